// File: rtl/vid_timing_if.sv
// Raster timing bundle between vid_timing_gen and its consumers.
// The generator takes pix_en in and drives the pixel stream and monitor levels.
interface vid_timing_if;
  logic pix_en;
  logic out_req;
  logic out_eol;
  logic out_eof;
  logic out_vsync;
  logic out_blank;
  logic vga_hsync;
  logic vga_vsync;

  modport master (
    input  pix_en,
    output out_req,
    output out_eol,
    output out_eof,
    output out_vsync,
    output out_blank,
    output vga_hsync,
    output vga_vsync
  );

  modport slave (
    output pix_en,
    input  out_req,
    input  out_eol,
    input  out_eof,
    input  out_vsync,
    input  out_blank,
    input  vga_hsync,
    input  vga_vsync
  );
endinterface

// File: rtl/vid_timing_gen.sv
// Programmable raster timing generator, pixel rate set by pix_en.
// Outputs are registered decodes of the position held before the advance.
module vid_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1
) (
  input  logic clk,
  input  logic reset_,
  vid_timing_if.master vif
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;

  // One extra bit so sync ends at the very
  // last count (total = 4096/2048) still fit.
  localparam logic [12:0] HA =
    13'(H_ACTIVE);
  localparam logic [12:0] HA_L =
    13'(H_ACTIVE - 1);
  localparam logic [12:0] HS_B =
    13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_E =
    13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_END =
    12'(H_TOTAL - 1);

  localparam logic [11:0] VA =
    12'(V_ACTIVE);
  localparam logic [11:0] VA_L =
    12'(V_ACTIVE - 1);
  localparam logic [11:0] VS_B =
    12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_E =
    12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_END =
    11'(V_TOTAL - 1);

  localparam logic HP = 1'(H_POL);
  localparam logic VP = 1'(V_POL);

  logic [11:0] h, h_nxt;
  logic [10:0] v, v_nxt;
  logic [12:0] hx;
  logic [11:0] vx;

  logic active, eol_d, eof_d, vsp_d;
  logic hs_on, vs_on;

  logic req_q, eol_q, eof_q, vsp_q;
  logic blank_q, hs_q, vs_q;

  always_comb begin
    hx = {1'b0, h};
    vx = {1'b0, v};
    active = (hx < HA) && (vx < VA);
    eol_d  = active && (hx == HA_L);
    eof_d  = eol_d && (vx == VA_L);
    vsp_d  = (h == '0) && (vx == VS_B);
    hs_on  = (hx >= HS_B) && (hx < HS_E);
    vs_on  = (vx >= VS_B) && (vx < VS_E);
  end

  always_comb begin
    h_nxt = h;
    v_nxt = v;
    unique case (1'b1)
      !vif.pix_en: ;
      vif.pix_en && (h != H_END):
        h_nxt = h + 12'd1;
      vif.pix_en && (h == H_END): begin
        h_nxt = '0;
        v_nxt = (v == V_END) ? '0
                             : v + 11'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      h       <= '0;
      v       <= '0;
      req_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      vsp_q   <= 1'b0;
      blank_q <= 1'b1;
      hs_q    <= ~HP;
      vs_q    <= ~VP;
    end else begin
      h     <= h_nxt;
      v     <= v_nxt;
      req_q <= vif.pix_en && active;
      eol_q <= vif.pix_en && eol_d;
      eof_q <= vif.pix_en && eof_d;
      vsp_q <= vif.pix_en && vsp_d;
      // Levels only move on pixel strobes.
      if (vif.pix_en) begin
        blank_q <= !active;
        hs_q    <= hs_on ? HP : ~HP;
        vs_q    <= vs_on ? VP : ~VP;
      end
    end
  end

  assign vif.out_req   = req_q;
  assign vif.out_eol   = eol_q;
  assign vif.out_eof   = eof_q;
  assign vif.out_vsync = vsp_q;
  assign vif.out_blank = blank_q;
  assign vif.vga_hsync = hs_q;
  assign vif.vga_vsync = vs_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen on a small 8x6 raster.
// Reference tracks a linear pixel index within the frame.
module tb_vid_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HPOL = 0, VPOL = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  logic clk = 1'b0;
  logic reset_;
  always #5 clk = ~clk;

  vid_timing_if vif ();

  vid_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF),
    .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VS), .V_BP(VB),
    .H_POL(HPOL), .V_POL(VPOL)
  ) dut (
    .clk(clk),
    .reset_(reset_),
    .vif(vif.master)
  );

  int compared = 0;
  int mismatched = 0;

  int pos;
  logic e_req, e_eol, e_eof, e_vsp;
  logic e_blank, e_hs, e_vs;

  int n_req, n_eol, n_eof, n_vsp;
  int n_consec;
  logic prev_pulse;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic model(input logic rst,
                       input logic en);
    int hh, vv;
    if (!rst) begin
      pos = 0;
      e_req = 0; e_eol = 0; e_eof = 0; e_vsp = 0;
      e_blank = 1;
      e_hs = 1'(1 - HPOL);
      e_vs = 1'(1 - VPOL);
    end else if (en) begin
      hh = pos % HT;
      vv = pos / HT;
      e_req   = hh < HA && vv < VA;
      e_eol   = e_req && hh == HA - 1;
      e_eof   = e_eol && vv == VA - 1;
      e_vsp   = hh == 0 && vv == VA + VF;
      e_blank = !e_req;
      e_hs = (hh >= HA + HF && hh < HA + HF + HS)
             ? 1'(HPOL) : 1'(1 - HPOL);
      e_vs = (vv >= VA + VF && vv < VA + VF + VS)
             ? 1'(VPOL) : 1'(1 - VPOL);
      pos = (pos + 1) % FR;
    end else begin
      e_req = 0; e_eol = 0; e_eof = 0; e_vsp = 0;
    end
  endtask

  task automatic step(input logic rst,
                      input logic en);
    logic pulse;
    reset_ = rst;
    vif.pix_en = en;
    @(posedge clk);
    model(rst, en);
    #1;
    chk("req",   32'(vif.out_req),   32'(e_req));
    chk("eol",   32'(vif.out_eol),   32'(e_eol));
    chk("eof",   32'(vif.out_eof),   32'(e_eof));
    chk("vsync", 32'(vif.out_vsync), 32'(e_vsp));
    chk("blank", 32'(vif.out_blank), 32'(e_blank));
    chk("hsync", 32'(vif.vga_hsync), 32'(e_hs));
    chk("vsync_lvl", 32'(vif.vga_vsync), 32'(e_vs));
    n_req += int'(vif.out_req);
    n_eol += int'(vif.out_eol);
    n_eof += int'(vif.out_eof);
    n_vsp += int'(vif.out_vsync);
    pulse = vif.out_req | vif.out_vsync;
    if (pulse && prev_pulse) n_consec++;
    prev_pulse = pulse;
  endtask

  task automatic clr();
    n_req = 0; n_eol = 0; n_eof = 0; n_vsp = 0;
    n_consec = 0;
    prev_pulse = 0;
  endtask

  initial begin
    int eol_mask;
    int eof_at;
    int cnt;
    pos = 0;
    clr();
    reset_ = 1'b0;
    vif.pix_en = 1'b0;

    // Reset state, with pix_en both ways.
    step(0, 0);
    step(0, 1);

    // Continuous pixels: one full frame.
    clr();
    eol_mask = 0;
    eof_at = -1;
    for (int i = 1; i <= FR; i++) begin
      step(1, 1);
      if (vif.out_eol) eol_mask |= (1 << i);
      if (vif.out_eof) eof_at = i;
    end
    chk("req_count", n_req, 12);
    chk("eol_count", n_eol, 3);
    chk("eof_count", n_eof, 1);
    chk("vsp_count", n_vsp, 1);
    chk("eol_cycles", eol_mask,
        (1 << 4) | (1 << 12) | (1 << 20));
    chk("eof_cycle", eof_at, 20);

    // Second frame: eof repeats 48 later.
    eof_at = -1;
    for (int i = 1; i <= FR; i++) begin
      step(1, 1);
      if (vif.out_eof) eof_at = i;
    end
    chk("eof_repeat", eof_at, 20);

    // Half-rate pixels: frame spans 96 cycles.
    clr();
    for (int i = 0; i < 2 * FR; i++)
      step(1, (i % 2) == 0);
    chk("half_req", n_req, 12);
    chk("half_eof", n_eof, 1);
    chk("half_vsp", n_vsp, 1);
    chk("half_consec", n_consec, 0);

    // Reset mid-frame at (2,1).
    step(0, 1);
    for (int i = 0; i < HT + 2; i++)
      step(1, 1);
    step(0, 1);
    chk("rst_req", 32'(vif.out_req), 0);
    chk("rst_blank", 32'(vif.out_blank), 1);
    chk("rst_hs", 32'(vif.vga_hsync),
        32'(1 - HPOL));
    chk("rst_vs", 32'(vif.vga_vsync),
        32'(1 - VPOL));
    cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      step(1, 1);
      if (vif.out_eol) cnt = i;
    end
    chk("rst_eol_at", cnt, 4);

    // Random pix_en with rare resets.
    for (int i = 0; i < 3000; i++)
      step(($urandom % 150) != 0,
           ($urandom % 4) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
